// File: rtl/fir_fft_framer.sv
`default_nettype none
// ============================================================================
// Module  : fir_fft_framer
// Brief   : Requantizes wide FIR samples to OUT_W bits and streams complete
//           FRAME_LEN-sample frames from a ping-pong buffer to the FFT stage.
// Revision: 1.0 - initial release
// ============================================================================
module fir_fft_framer #(
  parameter int IN_W      = 65,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 15,
  parameter int FRAME_LEN = 64,
  parameter int BITREV    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             sat,
  output logic             drop_err
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int XW = IN_W + 1;
  localparam logic signed [XW-1:0] c_half = XW'(1) << (SHIFT - 1);
  localparam logic signed [XW-1:0] c_max  = (XW'(1) << (OUT_W - 1)) - XW'(1);
  localparam logic signed [XW-1:0] c_min  = ~c_max;
  localparam logic [AW-1:0]        c_last = AW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_LAST   = 2'd2
  } state_t;

  // One extra bit of headroom keeps the rounding add from overflowing.
  logic signed [XW-1:0] w_sum, w_q;
  logic                 w_hi, w_lo;
  logic [OUT_W-1:0]     w_qsat;

  always_comb begin
    w_sum  = $signed({in_data[IN_W-1], in_data}) + c_half;
    w_q    = w_sum >>> SHIFT;
    w_hi   = (w_q > c_max);
    w_lo   = (w_q < c_min);
    w_qsat = w_hi ? c_max[OUT_W-1:0] : (w_lo ? c_min[OUT_W-1:0] : w_q[OUT_W-1:0]);
  end

  logic [OUT_W-1:0] r_mem [2*FRAME_LEN];
  logic             r_wbank, r_rbank;
  logic [AW-1:0]    r_widx, r_pos;
  logic [1:0]       r_full, w_full_nxt;
  state_t           r_state, w_state_nxt;

  logic w_rel, w_stall, w_unstall, w_tgt, w_acc, w_drop, w_last, w_toggle;

  // A writer parked on a full bank may move to the other bank the moment
  // that bank's eop word is accepted, taking the current sample with it.
  always_comb begin
    w_rel      = out_valid & out_ready & out_eop;
    w_stall    = r_full[r_wbank];
    w_unstall  = w_stall & w_rel & (r_rbank != r_wbank);
    w_tgt      = r_wbank ^ w_stall;
    w_acc      = in_valid & (~w_stall | w_unstall);
    w_drop     = in_valid & w_stall & ~w_unstall;
    w_last     = w_acc & (r_widx == c_last);
    w_toggle   = ~r_full[~w_tgt] | (w_rel & (r_rbank == ~w_tgt));
    w_full_nxt = r_full;
    if (w_rel)  w_full_nxt[r_rbank] = 1'b0;
    if (w_last) w_full_nxt[w_tgt]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_mem[{w_tgt, r_widx}] <= w_qsat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbank  <= 1'b0;
      r_widx   <= '0;
      r_full   <= '0;
      sat      <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      sat    <= w_acc & (w_hi | w_lo);
      if (w_drop) drop_err <= 1'b1;
      if (w_last) begin
        r_widx  <= '0;
        r_wbank <= w_toggle ? ~w_tgt : w_tgt;
      end else begin
        if (w_acc)     r_widx  <= r_widx + AW'(1);
        if (w_unstall) r_wbank <= ~r_wbank;
      end
    end
  end

  logic          w_adv, w_fetch, w_fetch_bank, w_rbank_nxt;
  logic [AW-1:0] w_fetch_pos, w_pos_nxt, w_fpos_rev, w_faddr;

  always_comb begin
    w_adv        = ~out_valid | out_ready;
    w_state_nxt  = r_state;
    w_rbank_nxt  = r_rbank;
    w_pos_nxt    = r_pos;
    w_fetch      = 1'b0;
    w_fetch_bank = r_rbank;
    w_fetch_pos  = r_pos;
    case (r_state)
      S_IDLE: if (r_full[r_rbank]) w_state_nxt = S_STREAM;
      S_STREAM: if (w_adv) begin
        w_fetch   = 1'b1;
        w_pos_nxt = r_pos + AW'(1);
        if (r_pos == c_last) w_state_nxt = S_LAST;
      end
      // Chaining straight into a waiting bank keeps back-to-back frames gapless.
      S_LAST: if (w_rel) begin
        w_rbank_nxt = ~r_rbank;
        w_pos_nxt   = '0;
        if (r_full[~r_rbank]) begin
          w_fetch      = 1'b1;
          w_fetch_bank = ~r_rbank;
          w_fetch_pos  = '0;
          w_pos_nxt    = AW'(1);
          w_state_nxt  = S_STREAM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < AW; i++) w_fpos_rev[i] = w_fetch_pos[AW-1-i];
    w_faddr = (BITREV != 0) ? w_fpos_rev : w_fetch_pos;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rbank   <= 1'b0;
      r_pos     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rbank <= w_rbank_nxt;
      r_pos   <= w_pos_nxt;
      if (w_fetch) begin
        out_valid <= 1'b1;
        out_data  <= r_mem[{w_fetch_bank, w_faddr}];
        out_sop   <= (w_fetch_pos == '0);
        out_eop   <= (w_fetch_pos == c_last);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_fft_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fir_fft_framer
// Brief   : Self-checking bench for fir_fft_framer (SHIFT=15, FRAME_LEN=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fir_fft_framer;

  localparam int IN_W  = 65;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  localparam int FL    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_ready = 1'b0;
  logic             out_valid, out_sop, out_eop, sat, drop_err;
  logic [OUT_W-1:0] out_data;

  fir_fft_framer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .FRAME_LEN(FL), .BITREV(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .sat(sat), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bitrev(input int p);
    int r = 0;
    for (int i = 0; i < 3; i++) r = (r << 1) | ((p >> i) & 1);
    return r;
  endfunction

  function automatic logic signed [OUT_W-1:0] requant(input logic signed [IN_W-1:0] x, output bit clamped);
    logic signed [IN_W+8:0] v;
    v = x;
    v = (v + 16384) >>> SHIFT;
    clamped = 1'b1;
    if (v > 32767) return 16'sd32767;
    if (v < -32768) return -16'sd32768;
    clamped = 1'b0;
    return v[OUT_W-1:0];
  endfunction

  // Reference model: counts full frames held, queues expected output words.
  typedef struct { logic signed [OUT_W-1:0] d; bit sop; bit eop; } word_t;
  word_t                   expq[$];
  logic signed [OUT_W-1:0] part[$];
  logic signed [OUT_W-1:0] log_q[$];
  int  held = 0;
  bit  exp_sat = 0, exp_drop = 0;
  bit  prev_hold = 0, prev_sop, prev_eop;
  logic [OUT_W-1:0] prev_data;
  bit  track_gaps = 0;
  int  gaps = 0;
  bit  m_rel, m_cl;
  word_t m_w;
  logic signed [OUT_W-1:0] m_q;

  always @(negedge clk) begin
    chk("sat", sat, exp_sat);
    chk("drop_err", drop_err, exp_drop);
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
      chk("hold_sop", out_sop, prev_sop);
      chk("hold_eop", out_eop, prev_eop);
    end
    if (track_gaps && log_q.size() > 0 && log_q.size() < 24 && !out_valid) gaps++;
    if (rst) begin
      held = 0; part.delete(); expq.delete();
      exp_sat = 0; exp_drop = 0; prev_hold = 0;
    end else begin
      m_rel = 1'b0;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word: got %0d expected no word", $signed(out_data));
        end else begin
          m_w = expq.pop_front();
          chk("word_data", $signed(out_data), m_w.d);
          chk("word_sop", out_sop, m_w.sop);
          chk("word_eop", out_eop, m_w.eop);
        end
        log_q.push_back($signed(out_data));
        m_rel = out_eop;
      end
      exp_sat = 1'b0;
      if (in_valid) begin
        if (held - int'(m_rel) < 2) begin
          m_q = requant($signed(in_data), m_cl);
          exp_sat = m_cl;
          part.push_back(m_q);
          if (part.size() == FL) begin
            for (int p = 0; p < FL; p++) begin
              m_w.d = part[bitrev(p)]; m_w.sop = (p == 0); m_w.eop = (p == FL-1);
              expq.push_back(m_w);
            end
            part.delete();
            held++;
          end
        end else begin
          exp_drop = 1'b1;
        end
      end
      held -= int'(m_rel);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data; prev_sop = out_sop; prev_eop = out_eop;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [IN_W-1:0] x);
    in_valid = 1'b1; in_data = x; tick(); in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (log_q.size() < n && t < 300) begin tick(); t++; end
    chk("drain_count", log_q.size(), n);
  endtask

  typedef struct { logic signed [IN_W-1:0] x; logic signed [OUT_W-1:0] q; bit s; } vec_t;
  vec_t tv[8];
  int   ord[8];
  logic [95:0] r96;
  logic signed [IN_W-1:0] rx;

  initial begin
    tv[0] = '{x: 65'sd16384,         q: 16'sd1,      s: 1'b0};
    tv[1] = '{x: 65'sd16383,         q: 16'sd0,      s: 1'b0};
    tv[2] = '{x: -65'sd16385,        q: -16'sd1,     s: 1'b0};
    tv[3] = '{x: 65'sd3276800,       q: 16'sd100,    s: 1'b0};
    tv[4] = '{x: 65'sd1099511627776, q: 16'sd32767,  s: 1'b1};
    tv[5] = '{x: -65'sd1099511627776,q: -16'sd32768, s: 1'b1};
    tv[6] = '{x: 65'sd1073725440,    q: 16'sd32767,  s: 1'b1};
    tv[7] = '{x: 65'sd0,             q: 16'sd0,      s: 1'b0};
    ord = '{0, 4, 2, 6, 1, 5, 3, 7};

    tick(); tick(); rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);

    // Rounding and saturation vectors
    out_ready = 1'b1; log_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(tv[i].x);
      chk("vec_sat", sat, tv[i].s);
    end
    drain(8);
    for (int p = 0; p < 8; p++) chk("vec_out", log_q[p], tv[bitrev(p)].q);
    tick();

    // Ordering and first-word latency
    log_q.delete();
    for (int k = 0; k < 8; k++) send(IN_W'(k * 32768));
    chk("lat_e0", out_valid, 0);
    tick(); chk("lat_e1", out_valid, 0);
    tick(); chk("lat_e2", out_valid, 1);
    chk("first_sop", out_sop, 1);
    chk("first_data", $signed(out_data), 0);
    drain(8);
    for (int p = 0; p < 8; p++) chk("order", log_q[p], ord[p]);
    tick();

    // Throughput: one idle slot where the writer is parked on a full bank
    log_q.delete(); gaps = 0; track_gaps = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 16) tick();
      send(IN_W'(i * 32768));
    end
    drain(24);
    track_gaps = 1'b0;
    chk("thr_gaps", gaps, 0);
    chk("thr_drop", drop_err, 0);
    for (int p = 0; p < 24; p++) chk("thr_data", log_q[p], (p / 8) * 8 + bitrev(p % 8));
    tick();

    // Backpressure and drop
    log_q.delete(); out_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(IN_W'((i + 10) * 32768));
    chk("bp_drop", drop_err, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_sop", out_sop, 1);
    chk("bp_data", $signed(out_data), 10);
    repeat (3) tick();
    chk("bp_held", $signed(out_data), 10);
    out_ready = 1'b1;
    drain(16);
    for (int p = 0; p < 16; p++) chk("bp_out", log_q[p], 10 + (p / 8) * 8 + bitrev(p % 8));
    tick();

    // Reset in the middle of a frame
    log_q.delete();
    for (int i = 0; i < 5; i++) send(IN_W'((100 + i) * 32768));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_sop", out_sop, 0);
    chk("mr_eop", out_eop, 0);
    chk("mr_sat", sat, 0);
    chk("mr_drop", drop_err, 0);
    for (int i = 0; i < 8; i++) send(IN_W'((200 + i) * 32768));
    drain(8);
    repeat (4) tick();
    chk("mr_count", log_q.size(), 8);
    for (int p = 0; p < 8; p++) chk("mr_out", log_q[p], 200 + bitrev(p));

    // Randomized traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      r96 = {$urandom(), $urandom(), $urandom()};
      rx = r96[IN_W-1:0];
      in_data = rx >>> $urandom_range(20, 64);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 200 && expq.size() > 0; t++) tick();
    chk("rand_drain", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
